// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: transmit FSM states, default FIFO depth, frame format.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_STOP_BITS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte buffer with registered full/empty/level and a sticky overflow flag.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AW    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  input  logic                      rd_en,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [AW:0]               level,
  output logic                      overflow
);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [UART_DATA_BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
  logic          push, pop;

  // Next-state for storage, pointers and flags; a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    push       = wr_en && (!full_q || rd_en);
    pop        = rd_en && !empty_q;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (wr_en & full_q & ~rd_en);
    if (push) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == (AW+1)'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Pointer, level and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data  = mem_q[rptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a req/done handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AW    = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      wr_en,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic                      full,
  output logic                      empty,
  output logic [AW:0]               level,
  output logic                      overflow,
  output logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_req,
  input  logic                      tx_done,
  output logic                      busy
);

  tx_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                      tx_req_q, tx_req_d;
  logic [UART_DATA_BITS-1:0] head;
  logic                      pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // Handshake FSM: pop in IDLE, pulse request in REQ, wait for frame completion in WAIT.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = ST_REQ;
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (tx_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    tx_req_d = (state_d == ST_REQ);
  end

  // FSM, latched byte and request pulse registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_req  = tx_req_q;
  assign busy    = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       full, empty, overflow, tx_req, busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int         req_cyc [$];
  logic [7:0] req_data[$];

  uart_tx_fifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Log every request pulse with its cycle number and byte.
  always @(negedge sys_clk) begin
    if (tx_req === 1'b1) begin
      req_cyc.push_back(cyc);
      req_data.push_back(tx_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_rst = 1'b1;
    wr_en   = 1'b0;
    tx_done = 1'b0;
    wr_data = 8'h00;
    tick();
    tick();
    sys_rst = 1'b0;
    req_cyc.delete();
    req_data.delete();
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    tick();
    tick();
    vectors++; if (level !== 5'd0)    begin miscompares++; $display("FAIL rst_level: got %0d want 0", level); end
    vectors++; if (empty !== 1'b1)    begin miscompares++; $display("FAIL rst_empty: got %b want 1", empty); end
    vectors++; if (full !== 1'b0)     begin miscompares++; $display("FAIL rst_full: got %b want 0", full); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    vectors++; if (tx_req !== 1'b0)   begin miscompares++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    sys_rst = 1'b0;
  endtask

  task automatic test_single;
    int n0;
    do_reset();
    n0 = cyc;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    vectors++; if (tx_req !== 1'b0) begin miscompares++; $display("FAIL single_req_n1: got %b want 0", tx_req); end
    vectors++; if (busy !== 1'b1)   begin miscompares++; $display("FAIL single_busy_n1: got %b want 1", busy); end
    tick();
    vectors++; if (tx_req !== 1'b1)    begin miscompares++; $display("FAIL single_req_n2: got %b want 1", tx_req); end
    vectors++; if (tx_data !== 8'hA5)  begin miscompares++; $display("FAIL single_data: got %h want a5", tx_data); end
    tick();
    vectors++; if (tx_req !== 1'b0)    begin miscompares++; $display("FAIL single_req_n3: got %b want 0", tx_req); end
    repeat (5) tick();
    vectors++; if (busy !== 1'b1)      begin miscompares++; $display("FAIL single_busy_wait: got %b want 1", busy); end
    vectors++; if (tx_data !== 8'hA5)  begin miscompares++; $display("FAIL single_data_hold: got %h want a5", tx_data); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_done: got %b want 0", busy); end
    vectors++;
    if (req_cyc.size() != 1) begin
      miscompares++; $display("FAIL single_pulses: got %0d want 1", req_cyc.size());
    end else if (req_cyc[0] != n0 + 2) begin
      miscompares++; $display("FAIL single_latency: got cycle %0d want %0d", req_cyc[0], n0 + 2);
    end
  endtask

  task automatic test_back_to_back;
    int n0, expect_cyc, r, m, t;
    do_reset();
    n0 = cyc;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    expect_cyc = n0 + 2;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (req_cyc.size() <= k && t < 100) begin tick(); t++; end
      vectors++;
      if (req_cyc.size() <= k) begin
        miscompares++; $display("FAIL b2b_timeout_%0d: got no tx_req want pulse", k);
      end else begin
        if (req_cyc[k] != expect_cyc) begin
          miscompares++; $display("FAIL b2b_cycle_%0d: got %0d want %0d", k, req_cyc[k], expect_cyc);
        end
        vectors++;
        if (req_data[k] !== 8'(k + 1)) begin
          miscompares++; $display("FAIL b2b_data_%0d: got %h want %h", k, req_data[k], 8'(k + 1));
        end
        r = req_cyc[k];
        while (cyc < r + 20) tick();
        tx_done = 1'b1;
        m = cyc;
        tick();
        tx_done = 1'b0;
        expect_cyc = m + 2;
      end
    end
    repeat (30) tick();
    vectors++; if (req_cyc.size() != 3) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 3", req_cyc.size()); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_b;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h0F;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL ovf_level_start: got %0d want 0", level); end
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
      if (i == 15) begin
        vectors++; if (full !== 1'b1)     begin miscompares++; $display("FAIL ovf_full_at16: got %b want 1", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    wr_en = 1'b0;
    vectors++; if (level !== 5'd16)   begin miscompares++; $display("FAIL ovf_level: got %0d want 16", level); end
    vectors++; if (full !== 1'b1)     begin miscompares++; $display("FAIL ovf_full: got %b want 1", full); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    vectors++; if (tx_req !== 1'b0)   begin miscompares++; $display("FAIL ovf_req_wait: got %b want 0", tx_req); end
    for (int j = 0; j < 16; j++) begin
      exp_b = 8'h10 + 8'(j);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      vectors++;
      if (tx_req !== 1'b1 || tx_data !== exp_b) begin
        miscompares++; $display("FAIL ovf_drain_%0d: got req=%b data=%h want req=1 data=%h", j, tx_req, tx_data, exp_b);
      end
      tick();
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL ovf_busy_end: got %b want 0", busy); end
    vectors++; if (overflow !== 1'b1)    begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    vectors++; if (req_cyc.size() != 17) begin miscompares++; $display("FAIL ovf_pulses: got %0d want 17", req_cyc.size()); end
  endtask

  task automatic test_full_pop;
    logic [7:0] exp_b;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h40;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h41 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    vectors++; if (full !== 1'b1 || level !== 5'd16) begin miscompares++; $display("FAIL fp_full_pre: got full=%b level=%0d want 1/16", full, level); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    vectors++; if (tx_req !== 1'b1)    begin miscompares++; $display("FAIL fp_req: got %b want 1", tx_req); end
    vectors++; if (tx_data !== 8'h41)  begin miscompares++; $display("FAIL fp_data: got %h want 41", tx_data); end
    vectors++; if (level !== 5'd16)    begin miscompares++; $display("FAIL fp_level: got %0d want 16", level); end
    vectors++; if (full !== 1'b1)      begin miscompares++; $display("FAIL fp_full: got %b want 1", full); end
    vectors++; if (overflow !== 1'b0)  begin miscompares++; $display("FAIL fp_overflow: got %b want 0", overflow); end
    tick();
    for (int j = 0; j < 16; j++) begin
      exp_b = (j < 15) ? 8'h42 + 8'(j) : 8'hEE;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      vectors++;
      if (tx_req !== 1'b1 || tx_data !== exp_b) begin
        miscompares++; $display("FAIL fp_drain_%0d: got req=%b data=%h want req=1 data=%h", j, tx_req, tx_data, exp_b);
      end
      tick();
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    vectors++; if (busy !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL fp_end: got busy=%b empty=%b want 0/1", busy, empty); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fp_overflow_end: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h61 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    vectors++; if (level !== 5'd5) begin miscompares++; $display("FAIL rm_level_pre: got %0d want 5", level); end
    vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL rm_busy_pre: got %b want 1", busy); end
    sys_rst = 1'b1;
    tick();
    vectors++; if (level !== 5'd0)  begin miscompares++; $display("FAIL rm_level: got %0d want 0", level); end
    vectors++; if (tx_req !== 1'b0) begin miscompares++; $display("FAIL rm_req: got %b want 0", tx_req); end
    vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL rm_busy: got %b want 0", busy); end
    sys_rst = 1'b0;
    req_cyc.delete();
    req_data.delete();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    vectors++; if (tx_req !== 1'b1 || tx_data !== 8'h3C) begin miscompares++; $display("FAIL rm_first: got req=%b data=%h want 1/3c", tx_req, tx_data); end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (10) tick();
    vectors++; if (req_cyc.size() != 1)      begin miscompares++; $display("FAIL rm_pulses: got %0d want 1", req_cyc.size()); end
    vectors++; if (busy !== 1'b0 || level !== 5'd0) begin miscompares++; $display("FAIL rm_end: got busy=%b level=%0d want 0/0", busy, level); end
  endtask

  task automatic test_done_ignored;
    do_reset();
    tx_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (busy !== 1'b0 || tx_req !== 1'b0) begin miscompares++; $display("FAIL di_idle_%0d: got busy=%b req=%b want 0/0", i, busy, tx_req); end
    end
    tx_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    tick();
    vectors++; if (tx_req !== 1'b1) begin miscompares++; $display("FAIL di_req: got %b want 1", tx_req); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    vectors++; if (tx_req !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL di_after_req: got req=%b busy=%b want 0/1", tx_req, busy); end
    repeat (5) tick();
    vectors++; if (busy !== 1'b1)        begin miscompares++; $display("FAIL di_still_wait: got %b want 1", busy); end
    vectors++; if (req_cyc.size() != 1)  begin miscompares++; $display("FAIL di_pulses: got %0d want 1", req_cyc.size()); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL di_done: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_done_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of 2, at least 2).
REQ-002 SHALL have parameter AW, default 4, pointer width; equals log2(DEPTH).
REQ-003 SHALL have port sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port wr_en  input  1  push wr_data this cycle.
REQ-006 SHALL have port wr_data  input  8  byte to queue.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port level  output  AW+1  current byte count, 0..DEPTH.
REQ-010 SHALL have port overflow  output  1  sticky; set by a push while full.
REQ-011 SHALL have port tx_data  output  8  byte offered to the UART transmitter.
REQ-012 SHALL have port tx_req  output  1  one-cycle start pulse to the transmitter.
REQ-013 SHALL have port tx_done  input  1  transmitter frame-complete pulse.
REQ-014 SHALL have port busy  output  1  high when state is not IDLE or the FIFO is not empty.

Function
REQ-015 SHALL store bytes in a circular buffer with wrapping AW-bit read and write pointers; order SHALL be first in, first out.
REQ-016 SHALL accept a push when wr_en=1 and full=0; level SHALL rise by 1 on the next edge.
REQ-017 SHALL drop a push when wr_en=1 and full=1; FIFO contents, level and pointers SHALL be unchanged, and overflow SHALL be set.
REQ-018 SHALL, on a simultaneous push and pop, perform both; level SHALL be unchanged (full=1 included, since the pop frees a slot in the same cycle).
REQ-019 SHALL run FSM states IDLE, REQ and WAIT, all registered.
REQ-020 IDLE: if empty=0, SHALL pop the head byte into the tx_data register and go to REQ; otherwise SHALL stay in IDLE.
REQ-021 REQ: SHALL drive tx_req=1 for exactly this one cycle, then go to WAIT.
REQ-022 WAIT: SHALL hold tx_req=0; SHALL go to IDLE on the first cycle tx_done=1.
REQ-023 SHALL ignore tx_done in IDLE and REQ.
REQ-024 SHALL hold tx_data stable from the pop until the next pop.
REQ-025 Latency: a push into an empty FIFO with FSM in IDLE at cycle N SHALL produce tx_req=1 at cycle N+2.
REQ-026 Back-to-back frames: tx_done=1 at cycle M with FIFO non-empty SHALL produce the next tx_req=1 at cycle M+2, one idle cycle after the transmitter returns to idle.
REQ-027 full, empty and level SHALL be registered and consistent on the same cycle.
REQ-028 tx_req SHALL never be asserted while the FSM is in WAIT.

Reset
REQ-029 SHALL, while sys_rst=1, set pointers=0, level=0, empty=1, full=0, overflow=0, state=IDLE, tx_req=0, tx_data=8'h00 and busy=0.
REQ-030 Reset mid-operation SHALL discard queued bytes and any outstanding WAIT; the first cycle after reset SHALL behave as a fresh IDLE.
REQ-031 overflow SHALL clear only on reset.

Structure
REQ-032 The shared UART package SHALL hold the FSM state encodings, the default DEPTH, and the frame-format constants (8 data bits, 2 stop bits).
REQ-033 The storage and pointer logic SHALL be a sub-module sync_fifo (parameters DEPTH and AW, 8-bit data); uart_tx_fifo SHALL contain the FSM and handshake logic.

Verification
REQ-034 Reset, push 8'hA5 at cycle N -> tx_req=1 at N+2 only, tx_data=8'hA5, busy=1 until tx_done.
REQ-035 Push 3 bytes 8'h01, 8'h02, 8'h03 back-to-back; return tx_done 20 cycles after each tx_req -> exactly 3 tx_req pulses, in order 01, 02, 03, each at tx_done+2.
REQ-036 With tx_done held 0, push 17 bytes -> FSM pops 1 byte then stays in WAIT; 16 bytes stored, full=1, level=16, 17th byte dropped, overflow=1.
REQ-037 full=1, assert tx_done in WAIT and push on the cycle the next pop occurs -> level stays 16, no overflow, pushed byte delivered last.
REQ-038 Assert sys_rst in WAIT with 5 bytes queued -> after reset level=0, tx_req=0, busy=0; a new push 8'h3C is delivered first, with no stale data.
REQ-039 Pulse tx_done in IDLE and REQ -> no state change, no extra tx_req.
